cmd_script_player: RTL and testbench
====================================

Name: cmd_script_player

Overview:
- Synthesizable successor to the directed move-test flow. It holds a parametrised script of 16-bit Knight commands and plays them in order to the RemoteComm command interface.
- Each command is sent only after the previous one has been sent and acknowledged. Every 8-bit response is checked against an expected code, under a per-command watchdog.
- Reports pass/fail, the failing command index and the error class.
- Sits between RemoteComm (cmd/snd_cmd/cmd_snt/resp_rdy/resp) and a bench or on-board self-test controller.

Parameters:
DEPTH, 16, script slots (power of 2, >=2); AW = $clog2(DEPTH)
TIMEOUT_CYCLES, 10000000, max clk cycles from snd_cmd pulse to resp_rdy per command
EXP_RESP, 8'hA5, response code required for every command
TW, 24, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load_en  in  1  write load_cmd into slot load_addr (ignored while busy)
load_addr  in  AW  script slot
load_cmd  in  16  command word
num_cmds  in  AW+1  commands to play (0..DEPTH), sampled on accepted start
start  in  1  begin playback (ignored while busy)
abort  in  1  terminate playback
cmd  out  16  command to RemoteComm
snd_cmd  out  1  one-cycle send strobe
cmd_snt  in  1  RemoteComm: command fully transmitted
resp_rdy  in  1  RemoteComm: response byte valid
resp  in  8  response byte
busy  out  1  playback in progress
done  out  1  sticky completion flag, cleared on accepted start
pass  out  1  valid when done: all commands answered with EXP_RESP
err_idx  out  AW  index of failing command (valid when done & !pass)
err_code  out  2  0 none, 1 bad resp, 2 cmd_snt timeout, 3 resp timeout/abort
cmds_done  out  AW+1  commands completed successfully

Behaviour:
- Reset (rst high at posedge): state IDLE. cmd=0, snd_cmd=0, busy=0, done=0, pass=0, err_idx=0, err_code=0, cmds_done=0, timeout counter=0. Script memory is not reset.
- Memory: DEPTH x 16 registers, written on load_en & !busy at posedge.
- FSM states: IDLE, SEND, WAIT_SNT, WAIT_RESP, FIN.
- IDLE:
  - start with num_cmds==0: go to FIN with pass=1, done=1 next cycle.
  - start with num_cmds>num_cmds-capacity is impossible by width; values >DEPTH saturate to DEPTH.
  - start otherwise: latch count, idx=0, clear done/pass/err/cmds_done, busy=1, go to SEND.
- SEND (1 cycle): cmd<=mem[idx] registered so it is valid with the strobe; snd_cmd=1 this cycle only; timer cleared; go to WAIT_SNT. cmd holds until the next SEND.
- WAIT_SNT: cmd_snt -> WAIT_RESP. resp_rdy here is ignored. timer==TIMEOUT_CYCLES-1 -> FIN with err_code=2.
- WAIT_RESP: timer keeps counting from the SEND cycle.
  - resp_rdy & resp==EXP_RESP: cmds_done++; if idx==count-1 go to FIN with pass=1, else idx++ and go to SEND. The next snd_cmd is exactly 1 cycle after resp_rdy.
  - resp_rdy & resp!=EXP_RESP: FIN, err_code=1.
  - timeout: FIN, err_code=3.
  - resp_rdy and timeout in the same cycle: resp_rdy wins.
- Failure: err_idx=idx, pass=0.
- FIN (1 cycle): done=1, busy=0, go to IDLE. done/pass/err hold until the next accepted start or rst.
- abort while busy: next cycle FIN, err_code=3, err_idx=idx, pass=0. abort in IDLE has no effect. abort beats resp_rdy in the same cycle.
- start or load_en while busy: ignored, no state change.
- rst mid-playback: immediate return to reset values. Any snd_cmd pulse in that cycle is suppressed.
- Latency: start to first snd_cmd = 1 cycle; last good resp_rdy to done = 2 cycles.

Test Plan:
- Load 0x0000, 0x3BF2, 0x27F1; num_cmds=3, start. RemoteComm model answers 0xA5 -> three snd_cmd pulses with cmd 0000/3BF2/27F1 in order; done=1, pass=1, cmds_done=3, err_code=0.
- 2-command script, second resp=0x5A -> done, pass=0, err_idx=1, err_code=1, cmds_done=1.
- TIMEOUT_CYCLES=100, cmd_snt never asserted -> done 100 cycles after the SEND cycle (+1 for FIN), err_code=2, err_idx=0.
- TIMEOUT_CYCLES=100, cmd_snt at cycle 10, no resp -> err_code=3. Repeat with resp_rdy (0xA5) exactly on the timeout cycle -> accepted, pass=1.
- num_cmds=0 start -> done=1, pass=1 two cycles later, no snd_cmd. Start/load pulses during playback leave cmd sequence and memory unchanged.
- abort during WAIT_RESP of cmd 2 -> err_code=3, err_idx=2. rst asserted mid-WAIT_SNT -> all outputs zero next cycle; a fresh start replays from slot 0.

Source files
------------

// File: rtl/cmd_script_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_script_player_if
//  Description : Command/response link between cmd_script_player and the
//                RemoteComm block.
//                  cmd      16  command word (player -> RemoteComm)
//                  snd_cmd   1  one-cycle send strobe (player -> RemoteComm)
//                  cmd_snt   1  command fully transmitted (RemoteComm -> player)
//                  resp_rdy  1  response byte valid (RemoteComm -> player)
//                  resp      8  response byte (RemoteComm -> player)
//                master : the script player side
//                slave  : the RemoteComm side
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmd_script_player_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output snd_cmd,
        input  cmd_snt,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  snd_cmd,
        output cmd_snt,
        output resp_rdy,
        output resp
    );
endinterface
`default_nettype wire

// File: rtl/cmd_script_player.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_script_player
//  Description : Holds a script of 16-bit Knight commands and plays them in
//                order to RemoteComm. Each command waits for cmd_snt and then
//                for a response byte, which must equal EXP_RESP, all under a
//                per-command watchdog counted from the send strobe.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                load_en/addr/cmd script memory write (ignored while busy)
//                num_cmds        commands to play, sampled on accepted start
//                start, abort    begin / terminate playback
//                rc_if           RemoteComm link (master modport)
//                busy, done      playback in progress / sticky completion
//                pass            all commands answered with EXP_RESP
//                err_idx         index of the failing command
//                err_code        0 none, 1 bad resp, 2 cmd_snt timeout,
//                                3 resp timeout or abort
//                cmds_done       commands completed successfully
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_script_player #(
    parameter int          DEPTH          = 16,
    parameter int          TIMEOUT_CYCLES = 10000000,
    parameter logic [7:0]  EXP_RESP       = 8'hA5,
    parameter int          TW             = 24,
    localparam int         AW             = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load_en,
    input  wire logic [AW-1:0] load_addr,
    input  wire logic [15:0]   load_cmd,
    input  wire logic [AW:0]   num_cmds,
    input  wire logic          start,
    input  wire logic          abort,
    cmd_script_player_if.master rc_if,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [AW-1:0]      err_idx,
    output logic [1:0]         err_code,
    output logic [AW:0]        cmds_done
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SEND      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_SNT  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] c_ST_FIN       = 3'd4;

    localparam logic [AW:0]   c_DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_ONE_W    = (AW+1)'(1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_RESP = 2'd1;
    localparam logic [1:0] c_ERR_SNT  = 2'd2;
    localparam logic [1:0] c_ERR_TMO  = 2'd3;

    logic [15:0]   r_mem [DEPTH];
    logic [2:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_cmd;
    logic          r_snd;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [AW-1:0] r_err_idx;
    logic [1:0]    r_err_code;
    logic [AW:0]   r_cmds_done;
    // Outcome staged on entry to FIN and published together with done.
    logic          r_res_pass;
    logic [1:0]    r_res_code;
    logic [AW-1:0] r_res_idx;

    logic [AW:0]   w_num_sat;
    logic [AW-1:0] w_idx_next;
    logic          w_last;
    logic          w_timeout;

    // The count port is one bit wider than the script, so clamp to DEPTH.
    assign w_num_sat  = (num_cmds > c_DEPTH_W) ? c_DEPTH_W : num_cmds;
    assign w_idx_next = r_idx + AW'(1);
    assign w_last     = ({1'b0, r_idx} == (r_count - c_ONE_W));
    // ">=" keeps a late cmd_snt (on the last WAIT_SNT cycle) from leaving
    // WAIT_RESP without a deadline; it then times out one cycle later.
    assign w_timeout  = (r_timer >= c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (load_en && !r_busy) begin
            r_mem[load_addr] <= load_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_cmd       <= '0;
            r_snd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_idx   <= '0;
            r_err_code  <= c_ERR_NONE;
            r_cmds_done <= '0;
            r_res_pass  <= 1'b0;
            r_res_code  <= c_ERR_NONE;
            r_res_idx   <= '0;
        end else begin
            r_snd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_idx   <= '0;
                        r_err_code  <= c_ERR_NONE;
                        r_cmds_done <= '0;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_count     <= w_num_sat;
                        if (w_num_sat == '0) begin
                            r_res_pass <= 1'b1;
                            r_res_code <= c_ERR_NONE;
                            r_res_idx  <= '0;
                            r_state    <= c_ST_FIN;
                        end else begin
                            // Command and strobe are launched together so
                            // cmd is valid in the strobe cycle.
                            r_cmd   <= r_mem[0];
                            r_snd   <= 1'b1;
                            r_timer <= '0;
                            r_state <= c_ST_SEND;
                        end
                    end
                end

                c_ST_SEND: begin
                    r_timer <= r_timer + TW'(1);
                    if (abort) begin
                        r_res_pass <= 1'b0;
                        r_res_code <= c_ERR_TMO;
                        r_res_idx  <= r_idx;
                        r_state    <= c_ST_FIN;
                    end else begin
                        r_state <= c_ST_WAIT_SNT;
                    end
                end

                c_ST_WAIT_SNT: begin
                    r_timer <= r_timer + TW'(1);
                    if (abort) begin
                        r_res_pass <= 1'b0;
                        r_res_code <= c_ERR_TMO;
                        r_res_idx  <= r_idx;
                        r_state    <= c_ST_FIN;
                    end else if (rc_if.cmd_snt) begin
                        r_state <= c_ST_WAIT_RESP;
                    end else if (w_timeout) begin
                        r_res_pass <= 1'b0;
                        r_res_code <= c_ERR_SNT;
                        r_res_idx  <= r_idx;
                        r_state    <= c_ST_FIN;
                    end
                end

                c_ST_WAIT_RESP: begin
                    r_timer <= r_timer + TW'(1);
                    if (abort) begin
                        r_res_pass <= 1'b0;
                        r_res_code <= c_ERR_TMO;
                        r_res_idx  <= r_idx;
                        r_state    <= c_ST_FIN;
                    end else if (rc_if.resp_rdy) begin
                        if (rc_if.resp == EXP_RESP) begin
                            r_cmds_done <= r_cmds_done + c_ONE_W;
                            if (w_last) begin
                                r_res_pass <= 1'b1;
                                r_res_code <= c_ERR_NONE;
                                r_res_idx  <= '0;
                                r_state    <= c_ST_FIN;
                            end else begin
                                r_idx   <= w_idx_next;
                                r_cmd   <= r_mem[w_idx_next];
                                r_snd   <= 1'b1;
                                r_timer <= '0;
                                r_state <= c_ST_SEND;
                            end
                        end else begin
                            r_res_pass <= 1'b0;
                            r_res_code <= c_ERR_RESP;
                            r_res_idx  <= r_idx;
                            r_state    <= c_ST_FIN;
                        end
                    end else if (w_timeout) begin
                        r_res_pass <= 1'b0;
                        r_res_code <= c_ERR_TMO;
                        r_res_idx  <= r_idx;
                        r_state    <= c_ST_FIN;
                    end
                end

                c_ST_FIN: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_pass     <= r_res_pass;
                    r_err_code <= r_res_code;
                    r_err_idx  <= r_res_idx;
                    r_state    <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rc_if.cmd     = r_cmd;
    assign rc_if.snd_cmd = r_snd;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_idx       = r_err_idx;
    assign err_code      = r_err_code;
    assign cmds_done     = r_cmds_done;

endmodule
`default_nettype wire

// File: tb/tb_cmd_script_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_script_player
//  Description : Self-checking bench for cmd_script_player. Each playback is
//                planned as a timeline (send, cmd_snt, response, finish
//                cycles) from the command/response rules; the RemoteComm
//                responses are driven from that plan and every cycle the DUT
//                outputs are compared with what the timeline implies.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmd_script_player;

    localparam int         DEPTH = 8;
    localparam int         AW    = 3;
    localparam int         T     = 100;
    localparam int         TW    = 16;
    localparam logic [7:0] EXP   = 8'hA5;
    localparam int         NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_cmd;
    logic [AW:0]   num_cmds;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] err_idx;
    logic [1:0]    err_code;
    logic [AW:0]   cmds_done;

    cmd_script_player_if bus ();

    cmd_script_player #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (T),
        .EXP_RESP       (EXP),
        .TW             (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_cmd  (load_cmd),
        .num_cmds  (num_cmds),
        .start     (start),
        .abort     (abort),
        .rc_if     (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_idx   (err_idx),
        .err_code  (err_code),
        .cmds_done (cmds_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Script contents as the bench believes them to be.
    logic [15:0] m_mem [DEPTH];

    // Timeline of the current playback.
    bit          pv = 1'b0;
    int          p_st, p_f, p_n, p_nsent, p_nok, p_abort;
    int          p_sc  [DEPTH];
    int          p_rc  [DEPTH];
    int          p_snt [DEPTH];
    int          p_rsp [DEPTH];
    logic [7:0]  p_rv  [DEPTH];
    logic [15:0] p_val [DEPTH];
    bit          f_pass;
    int          f_code, f_idx;

    // Outputs held from before the current playback.
    logic [15:0] h_cmd  = '0;
    bit          h_done = 1'b0;
    bit          h_pass = 1'b0;
    int          h_code = 0;
    int          h_idx  = 0;
    int          h_cnt  = 0;

    // Per-command RemoteComm behaviour for the next playback.
    int          k_ds   [DEPTH];
    int          k_dr   [DEPTH];
    logic [7:0]  k_rv   [DEPTH];
    bit          k_spur [DEPTH];

    bit          chk_en = 1'b0;
    logic [15:0] sent_q [$];
    int          snd_cyc_last = 0;
    int          done_rise    = 0;
    bit          prev_done    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic void build_plan(input int st, input int nreq, input int abort_at);
        int s, snt, dl, r, endc, code;
        p_st = st; p_abort = abort_at;
        p_n = (nreq > DEPTH) ? DEPTH : nreq;
        p_nsent = 0; p_nok = 0; f_pass = 1'b0; f_code = 0; f_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            p_sc[i] = NEVER; p_rc[i] = NEVER; p_snt[i] = NEVER; p_rsp[i] = NEVER;
        end
        p_f = st;
        if (p_n == 0) begin
            f_pass = 1'b1;
            return;
        end
        s = st + 1;
        for (int k = 0; k < p_n; k++) begin
            p_sc[k] = s; p_val[k] = m_mem[k]; p_rv[k] = k_rv[k]; p_nsent = k + 1;
            if (k_ds[k] <= T - 1) begin
                snt = s + k_ds[k];
                p_snt[k] = snt;
                dl = (s + T - 1 > snt + 1) ? s + T - 1 : snt + 1;
                r = snt + k_dr[k];
                if (r <= dl) begin
                    endc = r; p_rsp[k] = r;
                    code = (k_rv[k] == EXP) ? 0 : 1;
                end else begin
                    endc = dl; code = 3;
                end
            end else begin
                endc = s + T - 1; code = 2;
            end
            if (abort_at >= s && abort_at <= endc) begin
                p_f = abort_at; f_code = 3; f_idx = k;
                return;
            end
            if (code != 0) begin
                p_f = endc; f_code = code; f_idx = k;
                return;
            end
            p_rc[k] = endc; p_nok = k + 1; s = endc + 1;
            if (k == p_n - 1) begin
                p_f = endc; f_pass = 1'b1;
            end
        end
    endfunction

    // Advance one cycle and drive RemoteComm from the plan.
    task automatic step();
        @(posedge clk);
        #1;
        if (cyc > 90000) begin
            $display("FAIL cycle_guard: got %0d expected below 90000", cyc);
            $fatal(1, "cycle guard expired");
        end
        start = 1'b0; load_en = 1'b0; abort = 1'b0;
        bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0; bus.resp = 8'($urandom);
        if (pv) begin
            for (int k = 0; k < p_nsent; k++) begin
                if (cyc == p_snt[k] && cyc <= p_f) bus.cmd_snt = 1'b1;
                if (cyc == p_rsp[k] && cyc <= p_f) begin
                    bus.resp_rdy = 1'b1; bus.resp = p_rv[k];
                end
                // A good-looking response while still waiting for cmd_snt.
                if (k_spur[k] && cyc == p_sc[k] + 1 && cyc <= p_snt[k] && cyc <= p_f) begin
                    bus.resp_rdy = 1'b1; bus.resp = EXP;
                end
            end
            if (cyc == p_abort) abort = 1'b1;
        end
    endtask

    task automatic take_hold();
        if (pv) begin
            if (p_nsent > 0) h_cmd = p_val[p_nsent-1];
            h_done = 1'b1; h_pass = f_pass; h_code = f_code; h_idx = f_idx; h_cnt = p_nok;
        end
    endtask

    task automatic do_reset();
        step();
        chk_en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; pv = 1'b0;
        h_cmd = '0; h_done = 1'b0; h_pass = 1'b0; h_code = 0; h_idx = 0; h_cnt = 0;
        chk_en = 1'b1;
    endtask

    task automatic load(input int addr, input logic [15:0] val);
        step();
        load_en = 1'b1; load_addr = AW'(addr); load_cmd = val;
        m_mem[addr] = val;
    endtask

    task automatic easy_knobs();
        for (int k = 0; k < DEPTH; k++) begin
            k_ds[k] = 1; k_dr[k] = 1; k_rv[k] = EXP; k_spur[k] = 1'b0;
        end
    endtask

    // abort_k: -1 none, -2 random cycle, >=0 two cycles after cmd_snt of that command
    task automatic run(input int nreq, input int abort_k, input bit poke);
        int ab, pk;
        ab = -1; pk = -1;
        step();
        take_hold();
        build_plan(cyc, nreq, -1);
        if (abort_k == -2 && p_n > 0) ab = int'($urandom_range(p_f, cyc + 1));
        else if (abort_k >= 0) ab = p_snt[abort_k] + 2;
        if (ab >= 0) build_plan(cyc, nreq, ab);
        pv = 1'b1; start = 1'b1; num_cmds = (AW+1)'(nreq);
        if (poke) pk = int'($urandom_range(p_f + 1, cyc + 1));
        while (cyc < p_f + 3) begin
            step();
            if (cyc == pk) begin
                start = 1'b1; num_cmds = (AW+1)'($urandom);
                load_en = 1'b1; load_addr = AW'($urandom); load_cmd = 16'($urandom);
            end
            if (cyc == p_f + 2 && $urandom_range(3, 0) == 0) abort = 1'b1;
        end
    endtask

    // Per-cycle comparison against the planned timeline.
    logic [15:0] e_cmd;
    logic        e_snd, e_busy, e_done, e_pass;
    int          e_code, e_idx, e_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!pv || cyc <= p_st) begin
                e_cmd = h_cmd; e_snd = 1'b0; e_busy = 1'b0; e_done = h_done;
                e_pass = h_pass; e_code = h_code; e_idx = h_idx; e_cnt = h_cnt;
            end else begin
                e_cmd = h_cmd; e_snd = 1'b0;
                for (int k = 0; k < p_nsent; k++) begin
                    if (p_sc[k] <= cyc) e_cmd = p_val[k];
                    if (p_sc[k] == cyc) e_snd = 1'b1;
                end
                e_busy = (cyc <= p_f + 1);
                e_done = (cyc >= p_f + 2);
                e_pass = e_done && f_pass;
                e_code = e_done ? f_code : 0;
                e_idx  = e_done ? f_idx : 0;
                e_cnt  = 0;
                for (int k = 0; k < p_nok; k++) if (p_rc[k] < cyc) e_cnt++;
            end
            check("snd_cmd", 32'(bus.snd_cmd), 32'(e_snd));
            check("cmd", 32'(bus.cmd), 32'(e_cmd));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("pass", 32'(pass), 32'(e_pass));
            check("err_code", 32'(err_code), 32'(e_code));
            check("err_idx", 32'(err_idx), 32'(e_idx));
            check("cmds_done", 32'(cmds_done), 32'(e_cnt));
            if (bus.snd_cmd === 1'b1) begin
                sent_q.push_back(bus.cmd);
                snd_cyc_last = cyc;
            end
            if (done === 1'b1 && !prev_done) done_rise = cyc;
            prev_done = (done === 1'b1);
        end
    end

    int t_st;

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_cmd = '0; num_cmds = '0;
        start = 1'b0; abort = 1'b0;
        bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0; bus.resp = '0;
        easy_knobs();
        repeat (2) step();
        do_reset();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_cmd", 32'(bus.cmd), 0);
        check("rst_snd", 32'(bus.snd_cmd), 0);
        check("rst_cnt", 32'(cmds_done), 0);

        for (int i = 0; i < DEPTH; i++) load(i, 16'($urandom));

        // Three-command script, all answered with the expected code
        load(0, 16'h0000); load(1, 16'h3BF2); load(2, 16'h27F1);
        easy_knobs();
        sent_q.delete();
        run(3, -1, 1'b0);
        check("t1_nsent", sent_q.size(), 3);
        if (sent_q.size() == 3) begin
            check("t1_cmd0", 32'(sent_q[0]), 32'h0000);
            check("t1_cmd1", 32'(sent_q[1]), 32'h3BF2);
            check("t1_cmd2", 32'(sent_q[2]), 32'h27F1);
        end
        check("t1_done", 32'(done), 1);
        check("t1_pass", 32'(pass), 1);
        check("t1_cnt", 32'(cmds_done), 3);
        check("t1_code", 32'(err_code), 0);
        check("t1_model_nok", p_nok, 3);

        // Bad second response
        easy_knobs(); k_rv[1] = 8'h5A;
        run(2, -1, 1'b0);
        check("t2_pass", 32'(pass), 0);
        check("t2_idx", 32'(err_idx), 1);
        check("t2_code", 32'(err_code), 1);
        check("t2_cnt", 32'(cmds_done), 1);

        // cmd_snt never arrives
        easy_knobs(); k_ds[0] = NEVER;
        run(1, -1, 1'b0);
        check("t3_latency", done_rise - snd_cyc_last, T + 1);
        check("t3_code", 32'(err_code), 2);
        check("t3_idx", 32'(err_idx), 0);

        // cmd_snt at 10, no response
        easy_knobs(); k_ds[0] = 10; k_dr[0] = NEVER;
        run(1, -1, 1'b0);
        check("t4a_code", 32'(err_code), 3);

        // Response exactly on the timeout cycle is accepted
        easy_knobs(); k_ds[0] = 10; k_dr[0] = T - 1 - 10;
        run(1, -1, 1'b0);
        check("t4b_pass", 32'(pass), 1);

        // cmd_snt on the last WAIT_SNT cycle still counts
        easy_knobs(); k_ds[0] = T - 1; k_dr[0] = 1;
        run(1, -1, 1'b0);
        check("t4c_pass", 32'(pass), 1);

        // Empty script
        sent_q.delete();
        t_st = cyc + 1;
        run(0, -1, 1'b0);
        check("t5_latency", done_rise - t_st, 2);
        check("t5_nsent", sent_q.size(), 0);
        check("t5_pass", 32'(pass), 1);

        // Start/load pokes while busy
        easy_knobs(); k_ds[1] = 3; k_dr[2] = 4;
        run(4, -1, 1'b1);
        run(DEPTH + 5, -1, 1'b1);

        // Abort during WAIT_RESP of command 2
        easy_knobs();
        for (int k = 0; k < DEPTH; k++) k_ds[k] = 2;
        k_dr[2] = 20;
        run(4, 2, 1'b0);
        check("t6_code", 32'(err_code), 3);
        check("t6_idx", 32'(err_idx), 2);
        check("t6_pass", 32'(pass), 0);

        // Reset while waiting for cmd_snt, then replay from slot 0
        load(0, 16'h0000);
        easy_knobs(); k_ds[0] = NEVER;
        step(); take_hold(); build_plan(cyc, 3, -1);
        pv = 1'b1; start = 1'b1; num_cmds = (AW+1)'(3);
        repeat (5) step();
        do_reset();
        check("t7_busy", 32'(busy), 0);
        check("t7_snd", 32'(bus.snd_cmd), 0);
        check("t7_cmd", 32'(bus.cmd), 0);
        check("t7_code", 32'(err_code), 0);
        easy_knobs();
        sent_q.delete();
        run(2, -1, 1'b0);
        check("t7_first", (sent_q.size() > 0) ? 32'(sent_q[0]) : 32'hDEAD, 32'h0000);
        check("t7_pass", 32'(pass), 1);

        // Randomised playbacks
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2, 0) == 0)
                for (int j = 0; j < 3; j++) load(int'($urandom_range(DEPTH - 1, 0)), 16'($urandom));
            for (int k = 0; k < DEPTH; k++) begin
                k_ds[k]   = ($urandom_range(11, 0) == 0) ? NEVER : int'($urandom_range(4, 1));
                k_dr[k]   = ($urandom_range(11, 0) == 0) ? NEVER : int'($urandom_range(4, 1));
                k_rv[k]   = ($urandom_range(9, 0) == 0) ? 8'($urandom) : EXP;
                k_spur[k] = ($urandom_range(3, 0) == 0);
            end
            run(int'($urandom_range(12, 0)),
                ($urandom_range(5, 0) == 0) ? -2 : -1,
                ($urandom_range(2, 0) == 0));
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
